// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - LSB-first frame serializer feeding the sequence detector on x.
// Optional macro SERIALIZER_DET_RST_EN adds a one-cycle GAP state that pulses det_rst after each frame.
module bit_stream_serializer #(
  parameter int   WIDTH    = 41,
  parameter int   LEN_W    = 6,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             det_rst
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_len;
  logic             w_start;
  logic             w_stop;

  assign w_len   = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_start = load && !abort && (len != '0);
  // r_cnt holds the bits still to send after the one currently on x
  assign w_stop  = abort || (r_cnt == '0);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      ready   <= 1'b1;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
      det_rst <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          det_rst <= 1'b0;
          if (w_start) begin
            r_state <= S_SHIFT;
            r_shreg <= din >> 1;
            r_cnt   <= w_len - LEN_W'(1);
            ready   <= 1'b0;
            x       <= din[0];
            x_valid <= 1'b1;
            sof     <= 1'b1;
            eof     <= (w_len == LEN_W'(1));
          end else begin
            ready   <= 1'b1;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_stop) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
`ifdef SERIALIZER_DET_RST_EN
            r_state <= S_GAP;
            ready   <= 1'b0;
            det_rst <= 1'b1;
`else
            r_state <= S_IDLE;
            ready   <= 1'b1;
            det_rst <= 1'b0;
`endif
          end else begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt - LEN_W'(1);
            x       <= r_shreg[0];
            sof     <= 1'b0;
            eof     <= (r_cnt == LEN_W'(1));
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          det_rst <= 1'b0;
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          det_rst <= 1'b0;
          x       <= IDLE_BIT;
          x_valid <= 1'b0;
          sof     <= 1'b0;
          eof     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - directed plus random bench against a per-cycle expected-output queue.
module tb_bit_stream_serializer;

  localparam int WIDTH = 41;
  localparam int LEN_W = 6;
`ifdef SERIALIZER_DET_RST_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  typedef struct packed {
    logic x;
    logic v;
    logic sof;
    logic eof;
    logic rdy;
    logic drst;
  } rec_t;

  logic             clk;
  logic             r;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             ready, x, x_valid, sof, eof, det_rst;

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t exp_q[$];
  rec_t cur;

  bit_stream_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .r(r), .load(load), .din(din), .len(len), .abort(abort),
    .ready(ready), .x(x), .x_valid(x_valid), .sof(sof), .eof(eof), .det_rst(det_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic xx, v, s, e, rd, dr);
    rec_t t;
    t.x = xx; t.v = v; t.sof = s; t.eof = e; t.rdy = rd; t.drst = dr;
    return t;
  endfunction

  function automatic rec_t outs();
    return mk(x, x_valid, sof, eof, ready, det_rst);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (x,v,sof,eof,rdy,drst)", tag, got, want);
    end
  endtask

  // One clock: drive at negedge, update the model from what was visible, compare after the edge.
  task automatic step(input string tag, input bit ld, input logic [WIDTH-1:0] d,
                      input logic [LEN_W-1:0] l, input bit ab);
    int n;
    @(negedge clk);
    load = ld; din = d; len = l; abort = ab;
    if (ab && cur.v) begin
      exp_q.delete();
      if (MAC) exp_q.push_back(mk(1, 0, 0, 0, 0, 1));
    end else if (ld && !ab && cur.rdy && l != 0) begin
      n = (int'(l) > WIDTH) ? WIDTH : int'(l);
      for (int i = 0; i < n; i++)
        exp_q.push_back(mk(d[i], 1, i == 0, i == n - 1, 0, 0));
      if (MAC) exp_q.push_back(mk(1, 0, 0, 0, 0, 1));
    end
    @(posedge clk);
    #1;
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1, 0, 0, 0, 1, 0);
    check(tag, 32'(outs()), 32'(cur));
  endtask

  function automatic logic [WIDTH-1:0] rnd_din();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  initial begin
    logic [WIDTH-1:0] d;
    r = 1'b0; load = 1'b0; din = '0; len = '0; abort = 1'b0;
    cur = mk(1, 0, 0, 0, 1, 0);

    // T1 reset
    repeat (3) @(posedge clk);
    #1 check("T1_reset", 32'(outs()), 32'(mk(1, 0, 0, 0, 1, 0)));
    @(negedge clk) r = 1'b1;
    repeat (3) step("T1_hold", 0, '0, '0, 0);

    // T2 27-bit frame
    d = '0;
    d[26:0] = 27'b111111100100000010111001000;
    step("T2_load", 1, d, 6'd27, 0);
    repeat (30) step("T2_shift", 0, rnd_din(), 6'($urandom_range(0, 63)), 0);

    // T3 limits
    step("T3_len0", 1, rnd_din(), 6'd0, 0);
    step("T3_len0b", 0, '0, '0, 0);
    step("T3_len50", 1, rnd_din(), 6'd50, 0);
    repeat (44) step("T3_len50s", 0, '0, '0, 0);
    d = rnd_din(); d[0] = 1'b0;
    step("T3_len1", 1, d, 6'd1, 0);
    repeat (3) step("T3_len1s", 0, '0, '0, 0);

    // T4 busy load ignored, abort after bit 5
    step("T4_load", 1, rnd_din(), 6'd20, 0);
    repeat (4) step("T4_busy", 1, rnd_din(), 6'd5, 0);
    step("T4_abort", 0, '0, '0, 1);
    repeat (4) step("T4_after", 0, '0, '0, 0);
    step("T4_idle_abort", 0, '0, '0, 1);
    step("T4_idle", 0, '0, '0, 0);

    // T6 async reset mid-frame
    step("T6_load", 1, rnd_din(), 6'd41, 0);
    repeat (10) step("T6_shift", 0, '0, '0, 0);
    #3 r = 1'b0;
    #1 check("T6_async", 32'(outs()), 32'(mk(1, 0, 0, 0, 1, 0)));
    @(negedge clk) r = 1'b1;
    exp_q.delete();
    cur = mk(1, 0, 0, 0, 1, 0);
    step("T6_reload", 1, rnd_din(), 6'd8, 0);
    repeat (10) step("T6_clean", 0, '0, '0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("RND", ($urandom_range(0, 3) == 0), rnd_din(), 6'($urandom_range(0, 63)),
           ($urandom_range(0, 24) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
